operand_fetch: RTL and testbench

//  Addressing-mode sequencer directly upstream of the 6502 ALU.
//  - On start: reads operand bytes at PC+1/PC+2, walks zero-page/indirect pointers, forms the effective address (EA).
//  - Optionally reads the data byte at EA.
//  - Results: data byte drives ALUL1; EA drives the bus/store path; pc_next goes to the PC register.

---
 rtl/cpu6502_pkg.sv | 62 ++++++
 rtl/operand_fetch_ea_calc.sv | 25 ++
 rtl/operand_fetch.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_operand_fetch.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu6502_pkg.sv
// Shared 6502 types: addressing modes, ALU operations and the operand-fetch FSM states.
package cpu6502_pkg;

    typedef enum logic [3:0] {
        IMP  = 4'd0,
        IMM  = 4'd1,
        ZP   = 4'd2,
        ZPX  = 4'd3,
        ZPY  = 4'd4,
        ABS  = 4'd5,
        ABSX = 4'd6,
        ABSY = 4'd7,
        IND  = 4'd8,
        IZX  = 4'd9,
        IZY  = 4'd10,
        REL  = 4'd11
    } addr_mode_t;

    typedef enum logic [3:0] {
        ALU_ADC,
        ALU_SBC,
        ALU_AND,
        ALU_ORA,
        ALU_EOR,
        ALU_ASL,
        ALU_LSR,
        ALU_ROL,
        ALU_ROR,
        ALU_INC,
        ALU_DEC,
        ALU_CMP,
        ALU_BIT,
        ALU_PASS
    } ALU_operation_t;

    typedef enum logic [2:0] {
        FS_IDLE,
        FS_OPLO,
        FS_OPHI,
        FS_PTRLO,
        FS_PTRHI,
        FS_DATA,
        FS_DONE
    } fetch_state_t;

    // Codes beyond REL are treated as implied so they complete without bus traffic.
    function automatic addr_mode_t decode_mode(input logic [3:0] code);
        if (code > 4'd11) begin
            return IMP;
        end
        return addr_mode_t'(code);
    endfunction

    function automatic logic [15:0] insn_len(input addr_mode_t m);
        case (m)
            IMP:                 return 16'd1;
            ABS, ABSX, ABSY, IND: return 16'd3;
            default:             return 16'd2;
        endcase
    endfunction

endpackage

// File: rtl/operand_fetch_ea_calc.sv
// Combinational effective-address adder shared by the absolute-indexed, (zp),Y and branch paths.
module ea_calc
    import cpu6502_pkg::*;
(
    input  addr_mode_t        mode,
    input  logic [15:0]       base,
    input  logic [7:0]        index,
    input  logic signed [7:0] offset,
    output logic [15:0]       ea,
    output logic              page_cross
);

    logic signed [15:0] offset_ext;

    always_comb begin
        offset_ext = 16'(offset);
        if (mode == REL) begin
            ea = base + offset_ext;
        end else begin
            ea = base + {8'h00, index};
        end
        page_cross = (mode inside {ABSX, ABSY, IZY, REL}) && (ea[15:8] != base[15:8]);
    end

endmodule

// File: rtl/operand_fetch.sv
// 6502 addressing-mode sequencer: reads operand bytes, walks pointers, forms EA and optionally
// fetches the data byte at EA for the ALU.
module operand_fetch
    import cpu6502_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [3:0]  mode,
    input  logic        need_data,
    input  logic [15:0] pc,
    input  logic [7:0]  x_reg,
    input  logic [7:0]  y_reg,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        busy,
    output logic        done,
    output logic [15:0] ea,
    output logic [7:0]  operand,
    output logic [15:0] pc_next,
    output logic        page_cross
);

    fetch_state_t state_q, state_d;
    addr_mode_t   mode_q, mode_d;
    logic         need_q, need_d;
    logic [15:0]  pc_q, pc_d;
    logic [7:0]   x_q, x_d;
    logic [7:0]   y_q, y_d;
    logic [7:0]   o_q, o_d;
    logic [7:0]   lo_q, lo_d;
    logic [15:0]  mem_addr_q, mem_addr_d;
    logic         mem_rd_q, mem_rd_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [15:0]  ea_q, ea_d;
    logic [7:0]   operand_q, operand_d;
    logic [15:0]  pc_next_q, pc_next_d;
    logic         page_cross_q, page_cross_d;

    addr_mode_t        start_mode;
    logic [7:0]        index_sel;
    logic [15:0]       calc_base;
    logic [15:0]       calc_ea;
    logic              calc_pc;
    logic [7:0]        zp_lo;
    logic [7:0]        izx_lo;
    logic signed [7:0] rel_off;

    assign rel_off = $signed(mem_rdata);

    // The high byte arrives on the bus in the same cycle the EA is formed, so the adder
    // base is taken straight from mem_rdata in the cycles that complete an address.
    always_comb begin
        case (mode_q)
            ZPX, ABSX:      index_sel = x_q;
            ZPY, ABSY, IZY: index_sel = y_q;
            default:        index_sel = 8'h00;
        endcase
        case (state_q)
            FS_OPHI:  calc_base = {mem_rdata, o_q};
            FS_PTRHI: calc_base = {mem_rdata, lo_q};
            default:  calc_base = pc_q + 16'd2;
        endcase
        zp_lo  = mem_rdata + index_sel;
        izx_lo = mem_rdata + x_q;
    end

    ea_calc u_ea_calc (
        .mode       (mode_q),
        .base       (calc_base),
        .index      (index_sel),
        .offset     (rel_off),
        .ea         (calc_ea),
        .page_cross (calc_pc)
    );

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        need_d       = need_q;
        pc_d         = pc_q;
        x_d          = x_q;
        y_d          = y_q;
        o_d          = o_q;
        lo_d         = lo_q;
        mem_addr_d   = mem_addr_q;
        mem_rd_d     = mem_rd_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        ea_d         = ea_q;
        operand_d    = operand_q;
        pc_next_d    = pc_next_q;
        page_cross_d = page_cross_q;
        start_mode   = decode_mode(mode);

        case (state_q)
            FS_IDLE: begin
                if (start) begin
                    mode_d       = start_mode;
                    need_d       = need_data;
                    pc_d         = pc;
                    x_d          = x_reg;
                    y_d          = y_reg;
                    pc_next_d    = pc + insn_len(start_mode);
                    page_cross_d = 1'b0;
                    busy_d       = 1'b1;
                    if (start_mode == IMP) begin
                        ea_d      = 16'h0000;
                        operand_d = 8'h00;
                        done_d    = 1'b1;
                        state_d   = FS_DONE;
                    end else begin
                        mem_addr_d = pc + 16'd1;
                        mem_rd_d   = 1'b1;
                        state_d    = FS_OPLO;
                    end
                end
            end

            FS_OPLO: begin
                if (mem_ack) begin
                    o_d = mem_rdata;
                    case (mode_q)
                        IMM: begin
                            operand_d = mem_rdata;
                            ea_d      = pc_q + 16'd1;
                            mem_rd_d  = 1'b0;
                            done_d    = 1'b1;
                            state_d   = FS_DONE;
                        end
                        REL: begin
                            ea_d         = calc_ea;
                            page_cross_d = calc_pc;
                            mem_rd_d     = 1'b0;
                            done_d       = 1'b1;
                            state_d      = FS_DONE;
                        end
                        ZP, ZPX, ZPY: begin
                            ea_d = {8'h00, zp_lo};
                            if (need_q) begin
                                mem_addr_d = {8'h00, zp_lo};
                                state_d    = FS_DATA;
                            end else begin
                                mem_rd_d = 1'b0;
                                done_d   = 1'b1;
                                state_d  = FS_DONE;
                            end
                        end
                        IZX: begin
                            mem_addr_d = {8'h00, izx_lo};
                            state_d    = FS_PTRLO;
                        end
                        IZY: begin
                            mem_addr_d = {8'h00, mem_rdata};
                            state_d    = FS_PTRLO;
                        end
                        default: begin
                            mem_addr_d = pc_q + 16'd2;
                            state_d    = FS_OPHI;
                        end
                    endcase
                end
            end

            FS_OPHI: begin
                if (mem_ack) begin
                    if (mode_q == IND) begin
                        mem_addr_d = {mem_rdata, o_q};
                        state_d    = FS_PTRLO;
                    end else begin
                        ea_d         = calc_ea;
                        page_cross_d = calc_pc;
                        if (need_q) begin
                            mem_addr_d = calc_ea;
                            state_d    = FS_DATA;
                        end else begin
                            mem_rd_d = 1'b0;
                            done_d   = 1'b1;
                            state_d  = FS_DONE;
                        end
                    end
                end
            end

            // Pointer high byte sits at the next address within the same page: this gives
            // zero-page wrap for (zp) modes and the NMOS JMP ($xxFF) behaviour alike.
            FS_PTRLO: begin
                if (mem_ack) begin
                    lo_d       = mem_rdata;
                    mem_addr_d = {mem_addr_q[15:8], mem_addr_q[7:0] + 8'd1};
                    state_d    = FS_PTRHI;
                end
            end

            FS_PTRHI: begin
                if (mem_ack) begin
                    ea_d         = calc_ea;
                    page_cross_d = calc_pc;
                    if (need_q) begin
                        mem_addr_d = calc_ea;
                        state_d    = FS_DATA;
                    end else begin
                        mem_rd_d = 1'b0;
                        done_d   = 1'b1;
                        state_d  = FS_DONE;
                    end
                end
            end

            FS_DATA: begin
                if (mem_ack) begin
                    operand_d = mem_rdata;
                    mem_rd_d  = 1'b0;
                    done_d    = 1'b1;
                    state_d   = FS_DONE;
                end
            end

            FS_DONE: begin
                busy_d  = 1'b0;
                state_d = FS_IDLE;
            end

            default: begin
                mem_rd_d = 1'b0;
                busy_d   = 1'b0;
                state_d  = FS_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= FS_IDLE;
            mode_q       <= IMP;
            need_q       <= 1'b0;
            pc_q         <= 16'h0000;
            x_q          <= 8'h00;
            y_q          <= 8'h00;
            o_q          <= 8'h00;
            lo_q         <= 8'h00;
            mem_addr_q   <= 16'h0000;
            mem_rd_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ea_q         <= 16'h0000;
            operand_q    <= 8'h00;
            pc_next_q    <= 16'h0000;
            page_cross_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            need_q       <= need_d;
            pc_q         <= pc_d;
            x_q          <= x_d;
            y_q          <= y_d;
            o_q          <= o_d;
            lo_q         <= lo_d;
            mem_addr_q   <= mem_addr_d;
            mem_rd_q     <= mem_rd_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ea_q         <= ea_d;
            operand_q    <= operand_d;
            pc_next_q    <= pc_next_d;
            page_cross_q <= page_cross_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_rd     = mem_rd_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign ea         = ea_q;
    assign operand    = operand_q;
    assign pc_next    = pc_next_q;
    assign page_cross = page_cross_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed vector table, random walks against a reference model,
// and hand sequences for reset-in-flight and start/done overlap.
module tb_operand_fetch;
    import cpu6502_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        start;
    logic [3:0]  mode;
    logic        need_data;
    logic [15:0] pc;
    logic [7:0]  x_reg, y_reg;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        busy, done;
    logic [15:0] ea;
    logic [7:0]  operand;
    logic [15:0] pc_next;
    logic        page_cross;

    operand_fetch dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .start      (start),
        .mode       (mode),
        .need_data  (need_data),
        .pc         (pc),
        .x_reg      (x_reg),
        .y_reg      (y_reg),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .done       (done),
        .ea         (ea),
        .operand    (operand),
        .pc_next    (pc_next),
        .page_cross (page_cross)
    );

    always #5 Clk = ~Clk;

    logic [7:0] mem [0:65535];
    int wait_n = 0;
    int rd_cnt;
    int errors = 0;
    int checks = 0;

    // Memory responder: wait_n idle cycles, then one acknowledged cycle per read.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        rd_cnt    = 0;
        forever begin
            @(negedge Clk);
            if (mem_rd === 1'b1) begin
                if (rd_cnt >= wait_n) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem[mem_addr];
                    rd_cnt    = 0;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = 8'($urandom);
                    rd_cnt++;
                end
            end else begin
                mem_ack = 1'b0;
                rd_cnt  = 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, required a finished run");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Returns the number of clock edges from the accepting edge up to done, inclusive.
    task automatic run_op(input logic [3:0] m, input logic nd, input logic [15:0] p,
                          input logic [7:0] xi, input logic [7:0] yi, output int cyc);
        @(negedge Clk);
        mode = m; need_data = nd; pc = p; x_reg = xi; y_reg = yi; start = 1'b1;
        @(posedge Clk);
        cyc = 1;
        @(negedge Clk);
        start = 1'b0;
        mode = 4'($urandom); need_data = 1'($urandom);
        pc = 16'($urandom); x_reg = 8'($urandom); y_reg = 8'($urandom);
        while (done !== 1'b1 && cyc < 400) begin
            @(posedge Clk);
            cyc++;
            @(negedge Clk);
        end
        if (done !== 1'b1) chk("done_timeout", 32'(done), 32'd1);
    endtask

    // Reference: addressing-mode rules applied directly to the memory array.
    task automatic model(input logic [3:0] mc, input logic nd, input logic [15:0] p,
                         input logic [7:0] xi, input logic [7:0] yi,
                         output logic [15:0] e, output logic [7:0] op, output logic chk_op,
                         output logic [15:0] pn, output logic pcx, output int nrd);
        addr_mode_t am;
        logic [7:0]  o, h, lo, hi, zl, idx;
        logic [15:0] base;
        am = (mc > 4'd11) ? IMP : addr_mode_t'(mc);
        o = mem[p + 16'd1];
        h = mem[p + 16'd2];
        e = 16'h0000; op = 8'h00; chk_op = 1'b0; pcx = 1'b0; nrd = 0; pn = p + 16'd2;
        idx = (am == ZPX || am == ABSX) ? xi : ((am == ZPY || am == ABSY) ? yi : 8'h00);
        case (am)
            IMP: begin chk_op = 1'b1; pn = p + 16'd1; end
            IMM: begin e = p + 16'd1; op = o; chk_op = 1'b1; nrd = 1; end
            ZP, ZPX, ZPY: begin zl = o + idx; e = {8'h00, zl}; nrd = 1; end
            ABS, ABSX, ABSY: begin
                base = {h, o}; e = base + {8'h00, idx};
                pcx = (am != ABS) && (e[15:8] != h); nrd = 2; pn = p + 16'd3;
            end
            IND: begin
                lo = mem[{h, o}]; zl = o + 8'd1; hi = mem[{h, zl}];
                e = {hi, lo}; nrd = 4; pn = p + 16'd3;
            end
            IZX: begin
                zl = o + xi; lo = mem[{8'h00, zl}]; zl = zl + 8'd1; hi = mem[{8'h00, zl}];
                e = {hi, lo}; nrd = 3;
            end
            IZY: begin
                lo = mem[{8'h00, o}]; zl = o + 8'd1; hi = mem[{8'h00, zl}];
                base = {hi, lo}; e = base + {8'h00, yi}; pcx = (e[15:8] != hi); nrd = 3;
            end
            default: begin
                base = p + 16'd2; e = base + {{8{o[7]}}, o};
                pcx = (e[15:8] != base[15:8]); nrd = 1;
            end
        endcase
        if (nd && !(am inside {IMP, IMM, REL})) begin
            op = mem[e]; chk_op = 1'b1; nrd++;
        end
    endtask

    typedef struct {
        logic [3:0]  mode;
        logic        nd;
        logic [15:0] pc;
        logic [7:0]  x, y;
        int          wt;
        logic [15:0] ea;
        logic [7:0]  op;
        logic        chk_op;
        logic [15:0] pcn;
        logic        pcx;
        int          cyc;
    } vec_t;

    typedef struct {
        int          v;
        logic [15:0] a;
        logic [7:0]  d;
    } mw_t;

    vec_t vecs[$];
    mw_t  mws[$];

    task automatic addv(input logic [3:0] m, input logic nd, input logic [15:0] p,
                        input logic [7:0] xi, input logic [7:0] yi, input int wt,
                        input logic [15:0] e, input logic [7:0] op, input logic co,
                        input logic [15:0] pn, input logic pcx, input int cyc);
        vec_t t;
        t.mode = m; t.nd = nd; t.pc = p; t.x = xi; t.y = yi; t.wt = wt;
        t.ea = e; t.op = op; t.chk_op = co; t.pcn = pn; t.pcx = pcx; t.cyc = cyc;
        vecs.push_back(t);
    endtask

    task automatic addm(input int v, input logic [15:0] a, input logic [7:0] d);
        mw_t t;
        t.v = v; t.a = a; t.d = d;
        mws.push_back(t);
    endtask

    initial begin
        int          cyc;
        logic [15:0] e_ea, e_pn;
        logic [7:0]  e_op;
        logic        e_co, e_pcx;
        int          e_n;
        logic [3:0]  rm;
        logic        rn;
        logic [15:0] rp;
        logic [7:0]  rx, ry;

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

        addm(0, 16'h0401, 8'hF0); addm(0, 16'h0402, 8'h12); addm(0, 16'h1310, 8'h5A);
        addv(4'(ABSX), 1'b1, 16'h0400, 8'h20, 8'h00, 0, 16'h1310, 8'h5A, 1'b1, 16'h0403, 1'b1, 4);
        addv(4'(ABSX), 1'b1, 16'h0400, 8'h20, 8'h00, 1, 16'h1310, 8'h5A, 1'b1, 16'h0403, 1'b1, 7);
        addm(2, 16'h0201, 8'hF0);
        addv(4'(ZPX), 1'b0, 16'h0200, 8'h20, 8'h00, 0, 16'h0010, 8'h00, 1'b0, 16'h0202, 1'b0, 2);
        addm(3, 16'h0501, 8'hFF); addm(3, 16'h0502, 8'h02); addm(3, 16'h02FF, 8'h34);
        addm(3, 16'h0200, 8'h12); addm(3, 16'h0300, 8'h99);
        addv(4'(IND), 1'b0, 16'h0500, 8'h00, 8'h00, 0, 16'h1234, 8'h00, 1'b0, 16'h0503, 1'b0, 5);
        addm(4, 16'h0601, 8'hFF); addm(4, 16'h00FF, 8'hFF); addm(4, 16'h0000, 8'hFF);
        addv(4'(IZY), 1'b0, 16'h0600, 8'h00, 8'h01, 0, 16'h0000, 8'h00, 1'b0, 16'h0602, 1'b1, 4);
        addm(5, 16'h10FD, 8'h80);
        addv(4'(REL), 1'b0, 16'h10FC, 8'h00, 8'h00, 0, 16'h107E, 8'h00, 1'b0, 16'h10FE, 1'b0, 2);
        addm(6, 16'h10FD, 8'h02);
        addv(4'(REL), 1'b1, 16'h10FC, 8'h00, 8'h00, 0, 16'h1100, 8'h00, 1'b0, 16'h10FE, 1'b1, 2);
        addv(4'(IMP), 1'b1, 16'h2000, 8'h00, 8'h00, 0, 16'h0000, 8'h00, 1'b1, 16'h2001, 1'b0, 1);
        addm(8, 16'h3001, 8'h77);
        addv(4'(IMM), 1'b1, 16'h3000, 8'h00, 8'h00, 0, 16'h3001, 8'h77, 1'b1, 16'h3002, 1'b0, 2);
        addm(9, 16'h0701, 8'hF0); addm(9, 16'h0702, 8'hFF);
        addv(4'(ABSY), 1'b0, 16'h0700, 8'h00, 8'h20, 0, 16'h0010, 8'h00, 1'b0, 16'h0703, 1'b1, 3);
        addm(10, 16'h0801, 8'hF0); addm(10, 16'h0000, 8'hCD); addm(10, 16'h0001, 8'hAB);
        addm(10, 16'hABCD, 8'h42);
        addv(4'(IZX), 1'b1, 16'h0800, 8'h10, 8'h00, 0, 16'hABCD, 8'h42, 1'b1, 16'h0802, 1'b0, 5);
        addv(4'hE, 1'b1, 16'h2100, 8'h00, 8'h00, 0, 16'h0000, 8'h00, 1'b1, 16'h2101, 1'b0, 1);
        addm(12, 16'h0901, 8'h80); addm(12, 16'h0080, 8'h3C);
        addv(4'(ZP), 1'b1, 16'h0900, 8'h00, 8'h00, 2, 16'h0080, 8'h3C, 1'b1, 16'h0902, 1'b0, 7);

        Reset = 1'b1; start = 1'b0; mode = 4'h0; need_data = 1'b0;
        pc = 16'h0000; x_reg = 8'h00; y_reg = 8'h00;
        repeat (3) @(negedge Clk);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_page_cross", 32'(page_cross), 32'd0);
        chk("rst_ea", 32'(ea), 32'd0);
        chk("rst_operand", 32'(operand), 32'd0);
        chk("rst_pc_next", 32'(pc_next), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        Reset = 1'b0;

        foreach (vecs[i]) begin
            foreach (mws[j]) if (mws[j].v == i) mem[mws[j].a] = mws[j].d;
            wait_n = vecs[i].wt;
            run_op(vecs[i].mode, vecs[i].nd, vecs[i].pc, vecs[i].x, vecs[i].y, cyc);
            chk($sformatf("vec%0d_ea", i), 32'(ea), 32'(vecs[i].ea));
            chk($sformatf("vec%0d_pc_next", i), 32'(pc_next), 32'(vecs[i].pcn));
            chk($sformatf("vec%0d_page_cross", i), 32'(page_cross), 32'(vecs[i].pcx));
            chk($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vecs[i].cyc));
            if (vecs[i].chk_op) chk($sformatf("vec%0d_operand", i), 32'(operand), 32'(vecs[i].op));
        end

        // Start while busy is ignored; start coincident with done waits one cycle.
        wait_n = 1;
        @(negedge Clk);
        mode = 4'(ABSX); need_data = 1'b1; pc = 16'h0400; x_reg = 8'h20; y_reg = 8'h00; start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        @(negedge Clk);
        chk("busy_mid_walk", 32'(busy), 32'd1);
        mode = 4'(IMP); pc = 16'h5555; start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 50) begin @(negedge Clk); cyc++; end
        chk("busy_ign_done", 32'(done), 32'd1);
        chk("busy_ign_ea", 32'(ea), 32'h1310);
        chk("busy_ign_operand", 32'(operand), 32'h5A);
        chk("busy_ign_pc_next", 32'(pc_next), 32'h0403);
        mode = 4'(IMP); pc = 16'h6000; start = 1'b1;
        @(negedge Clk);
        chk("start_at_done_ignored", 32'(done), 32'd0);
        chk("start_at_done_hold", 32'(pc_next), 32'h0403);
        @(negedge Clk);
        start = 1'b0;
        chk("start_after_done_taken", 32'(done), 32'd1);
        chk("start_after_done_pc_next", 32'(pc_next), 32'h6001);

        // Reset pulsed while the ABS walk is waiting in its second read.
        wait_n = 3;
        mem[16'h0A01] = 8'h34; mem[16'h0A02] = 8'h12;
        @(negedge Clk);
        mode = 4'(ABS); need_data = 1'b0; pc = 16'h0A00; start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        cyc = 0;
        while (mem_addr !== 16'h0A02 && cyc < 50) begin @(negedge Clk); cyc++; end
        chk("reach_ophi", 32'(mem_addr), 32'h0A02);
        chk("ophi_busy", 32'(busy), 32'd1);
        chk("ophi_mem_rd", 32'(mem_rd), 32'd1);
        #2 Reset = 1'b1;
        #1;
        chk("async_mem_rd", 32'(mem_rd), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_done", 32'(done), 32'd0);
        chk("async_ea", 32'(ea), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        chk("post_rst_idle_busy", 32'(busy), 32'd0);
        chk("post_rst_idle_mem_rd", 32'(mem_rd), 32'd0);
        wait_n = 0;
        run_op(4'(ABS), 1'b0, 16'h0A00, 8'h00, 8'h00, cyc);
        chk("post_rst_ea", 32'(ea), 32'h1234);
        chk("post_rst_pc_next", 32'(pc_next), 32'h0A03);
        chk("post_rst_cycles", 32'(cyc), 32'd3);
        repeat (3) @(negedge Clk);
        chk("hold_ea", 32'(ea), 32'h1234);
        chk("hold_pc_next", 32'(pc_next), 32'h0A03);

        for (int k = 0; k < 150; k++) begin
            rm = 4'($urandom_range(0, 15));
            rn = 1'($urandom);
            rp = 16'($urandom);
            rx = 8'($urandom);
            ry = 8'($urandom);
            wait_n = $urandom_range(0, 2);
            model(rm, rn, rp, rx, ry, e_ea, e_op, e_co, e_pn, e_pcx, e_n);
            run_op(rm, rn, rp, rx, ry, cyc);
            chk($sformatf("rnd%0d_m%0h_ea", k, rm), 32'(ea), 32'(e_ea));
            chk($sformatf("rnd%0d_m%0h_pc_next", k, rm), 32'(pc_next), 32'(e_pn));
            chk($sformatf("rnd%0d_m%0h_page_cross", k, rm), 32'(page_cross), 32'(e_pcx));
            chk($sformatf("rnd%0d_m%0h_cycles", k, rm), 32'(cyc), 32'(e_n * (wait_n + 1) + 1));
            if (e_co) chk($sformatf("rnd%0d_m%0h_operand", k, rm), 32'(operand), 32'(e_op));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
